// File: rtl/bpu_btb_tagged.sv
// Tagged branch target buffer with per-entry saturating direction counters,
// a valid-sweep init/flush FSM and saturating accuracy statistics.
module bpu_btb_tagged #(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  output logic              ready_o,
  input  logic [ADDR_W-1:0] if_predict_pc_i,
  output logic              if_predict_hit_o,
  output logic              if_predict_taken_o,
  output logic [ADDR_W-1:0] if_predict_targetPc_o,
  input  logic              id_update_valid_i,
  input  logic [ADDR_W-1:0] id_update_pc_i,
  input  logic              id_update_isBranch_i,
  input  logic              id_update_taken_i,
  input  logic [ADDR_W-1:0] id_update_targetPc_i,
  input  logic              id_update_predTaken_i,
  output logic [31:0]       stat_update_o,
  output logic [31:0]       stat_mispred_o
);
  localparam int ENTRIES = 1 << INDEX_W;
  localparam logic [CNT_W-1:0] WEAK_T = CNT_W'(1) << (CNT_W-1);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t             r_state, w_state_nxt;
  logic [INDEX_W-1:0] r_sw, w_sw_nxt;
  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag [ENTRIES];
  logic [ADDR_W-1:0]  r_tgt [ENTRIES];
  logic [CNT_W-1:0]   r_cnt [ENTRIES];
  logic [31:0]        r_stat_upd, r_stat_mis;

  logic [INDEX_W-1:0] w_p_idx, w_u_idx;
  logic [TAG_W-1:0]   w_p_tag, w_u_tag;
  logic               w_p_hit, w_p_taken, w_u_hit, w_u_acc;
  logic [CNT_W-1:0]   w_cnt_cur, w_cnt_inc, w_cnt_dec;

  assign ready_o        = (r_state == ST_READY);
  assign stat_update_o  = r_stat_upd;
  assign stat_mispred_o = r_stat_mis;

  // Lookup reads the array as it stood before this edge: no update bypass.
  assign w_p_idx   = if_predict_pc_i[INDEX_W+1:2];
  assign w_p_tag   = if_predict_pc_i[INDEX_W+TAG_W+1:INDEX_W+2];
  assign w_p_hit   = ready_o & r_valid[w_p_idx] & (r_tag[w_p_idx] == w_p_tag);
  assign w_p_taken = w_p_hit & r_cnt[w_p_idx][CNT_W-1];

  assign if_predict_hit_o      = w_p_hit;
  assign if_predict_taken_o    = w_p_taken;
  assign if_predict_targetPc_o = w_p_taken ? r_tgt[w_p_idx] : if_predict_pc_i + ADDR_W'(4);

  assign w_u_idx   = id_update_pc_i[INDEX_W+1:2];
  assign w_u_tag   = id_update_pc_i[INDEX_W+TAG_W+1:INDEX_W+2];
  assign w_u_hit   = r_valid[w_u_idx] & (r_tag[w_u_idx] == w_u_tag);
  assign w_u_acc   = id_update_valid_i & ready_o & ~flush_i;
  assign w_cnt_cur = r_cnt[w_u_idx];
  assign w_cnt_inc = (w_cnt_cur == '1) ? w_cnt_cur : w_cnt_cur + CNT_W'(1);
  assign w_cnt_dec = (w_cnt_cur == '0) ? w_cnt_cur : w_cnt_cur - CNT_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_sw_nxt    = r_sw;
    case (r_state)
      ST_INIT: begin
        if (flush_i) begin
          w_sw_nxt = '0;
        end else begin
          w_sw_nxt = r_sw + INDEX_W'(1);
          if (r_sw == '1) w_state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        if (flush_i) begin
          w_state_nxt = ST_INIT;
          w_sw_nxt    = '0;
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_INIT;
      r_sw       <= '0;
      r_stat_upd <= '0;
      r_stat_mis <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sw    <= w_sw_nxt;
      if (w_u_acc) begin
        if (r_stat_upd != '1) r_stat_upd <= r_stat_upd + 32'd1;
        if ((id_update_predTaken_i != id_update_taken_i) && (r_stat_mis != '1))
          r_stat_mis <= r_stat_mis + 32'd1;
      end
    end
  end

  // Only valid bits are swept; tag/target/cnt are don't-care while invalid.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (r_state == ST_INIT) r_valid[r_sw] <= 1'b0;
      if (w_u_acc) begin
        if (w_u_hit) begin
          if (id_update_isBranch_i) begin
            if (id_update_taken_i) begin
              r_cnt[w_u_idx] <= w_cnt_inc;
              r_tgt[w_u_idx] <= id_update_targetPc_i;
            end else begin
              r_cnt[w_u_idx] <= w_cnt_dec;
            end
          end else begin
            r_valid[w_u_idx] <= 1'b0;
          end
        end else if (id_update_isBranch_i && id_update_taken_i) begin
          r_valid[w_u_idx] <= 1'b1;
          r_tag[w_u_idx]   <= w_u_tag;
          r_tgt[w_u_idx]   <= id_update_targetPc_i;
          r_cnt[w_u_idx]   <= WEAK_T;
        end
      end
    end
  end
endmodule

// File: tb/tb_bpu_btb_tagged.sv
// Directed bench for bpu_btb_tagged: init sweep, allocate/train, alias,
// same-cycle read/write, flush and statistics saturation.
module tb_bpu_btb_tagged;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        ready_o;
  logic [31:0] if_predict_pc_i = 32'h0000_1000;
  logic        if_predict_hit_o, if_predict_taken_o;
  logic [31:0] if_predict_targetPc_o;
  logic        id_update_valid_i = 1'b0;
  logic [31:0] id_update_pc_i = '0;
  logic        id_update_isBranch_i = 1'b0;
  logic        id_update_taken_i = 1'b0;
  logic [31:0] id_update_targetPc_i = '0;
  logic        id_update_predTaken_i = 1'b0;
  logic [31:0] stat_update_o, stat_mispred_o;

  int n_checks = 0;
  int n_errors = 0;

  bpu_btb_tagged dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .ready_o(ready_o),
    .if_predict_pc_i(if_predict_pc_i), .if_predict_hit_o(if_predict_hit_o),
    .if_predict_taken_o(if_predict_taken_o), .if_predict_targetPc_o(if_predict_targetPc_o),
    .id_update_valid_i(id_update_valid_i), .id_update_pc_i(id_update_pc_i),
    .id_update_isBranch_i(id_update_isBranch_i), .id_update_taken_i(id_update_taken_i),
    .id_update_targetPc_i(id_update_targetPc_i), .id_update_predTaken_i(id_update_predTaken_i),
    .stat_update_o(stat_update_o), .stat_mispred_o(stat_mispred_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic isb,
                         input logic tk, input logic [31:0] tgt, input logic pred);
    id_update_valid_i     = v;
    id_update_pc_i        = pc;
    id_update_isBranch_i  = isb;
    id_update_taken_i     = tk;
    id_update_targetPc_i  = tgt;
    id_update_predTaken_i = pred;
  endtask

  // One update applied at the next posedge; returns at posedge+1.
  task automatic upd(input logic [31:0] pc, input logic isb, input logic tk,
                     input logic [31:0] tgt, input logic pred);
    @(negedge clk_i);
    set_upd(1'b1, pc, isb, tk, tgt, pred);
    @(posedge clk_i); #1;
    id_update_valid_i = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                      input logic tk, input logic [31:0] tgt);
    if_predict_pc_i = pc;
    #1;
    check({tag, ".hit"}, {31'b0, if_predict_hit_o}, {31'b0, hit});
    check({tag, ".taken"}, {31'b0, if_predict_taken_o}, {31'b0, tk});
    check({tag, ".target"}, if_predict_targetPc_o, tgt);
  endtask

  task automatic stats(input string tag, input logic [31:0] u, input logic [31:0] m);
    check({tag, ".upd"}, stat_update_o, u);
    check({tag, ".mis"}, stat_mispred_o, m);
  endtask

  initial begin
    // Reset defaults
    repeat (3) @(posedge clk_i);
    #1;
    check("rst.ready", {31'b0, ready_o}, 32'd0);
    stats("rst", 32'd0, 32'd0);
    look("rst", 32'h0000_1000, 1'b0, 1'b0, 32'h0000_1004);

    // Init sweep: ready after exactly 64 edges; an update on the last INIT edge is dropped
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      set_upd(k == 64, 32'h8000_0010, 1'b1, 1'b1, 32'h8000_0100, 1'b0);
      @(posedge clk_i); #1;
      id_update_valid_i = 1'b0;
      check($sformatf("init.ready%0d", k), {31'b0, ready_o}, {31'b0, k == 64});
    end
    stats("init.drop", 32'd0, 32'd0);
    look("init.drop", 32'h8000_0010, 1'b0, 1'b0, 32'h8000_0014);

    // Allocate and hit
    upd(32'h8000_0010, 1'b1, 1'b1, 32'h8000_0100, 1'b1);
    look("alloc", 32'h8000_0010, 1'b1, 1'b1, 32'h8000_0100);
    stats("alloc", 32'd1, 32'd0);

    // Counter down 10->01->00->00
    upd(32'h8000_0010, 1'b1, 1'b0, 32'h0, 1'b1);
    look("dec1", 32'h8000_0010, 1'b1, 1'b0, 32'h8000_0014);
    upd(32'h8000_0010, 1'b1, 1'b0, 32'h0, 1'b0);
    upd(32'h8000_0010, 1'b1, 1'b0, 32'h0, 1'b0);
    look("dec3", 32'h8000_0010, 1'b1, 1'b0, 32'h8000_0014);
    stats("dec", 32'd4, 32'd1);

    // Counter up 00->01->10, target replaced
    upd(32'h8000_0010, 1'b1, 1'b1, 32'h8000_0200, 1'b0);
    look("inc1", 32'h8000_0010, 1'b1, 1'b0, 32'h8000_0014);
    upd(32'h8000_0010, 1'b1, 1'b1, 32'h8000_0200, 1'b0);
    look("inc2", 32'h8000_0010, 1'b1, 1'b1, 32'h8000_0200);
    stats("inc", 32'd6, 32'd3);

    // Tag alias: same index, different tag misses; not-taken miss writes nothing
    look("alias", 32'h8000_0110, 1'b0, 1'b0, 32'h8000_0114);
    upd(32'h8000_0110, 1'b1, 1'b0, 32'h8000_0999, 1'b0);
    look("alias.keep", 32'h8000_0010, 1'b1, 1'b1, 32'h8000_0200);
    look("alias.nowr", 32'h8000_0110, 1'b0, 1'b0, 32'h8000_0114);

    // Non-branch hit evicts
    upd(32'h8000_0010, 1'b0, 1'b0, 32'h0, 1'b0);
    look("evict", 32'h8000_0010, 1'b0, 1'b0, 32'h8000_0014);
    stats("evict", 32'd8, 32'd3);

    // Same-cycle lookup and allocate: old contents this cycle, new next
    @(negedge clk_i);
    set_upd(1'b1, 32'h8000_0020, 1'b1, 1'b1, 32'h8000_0400, 1'b1);
    look("rw.same", 32'h8000_0020, 1'b0, 1'b0, 32'h8000_0024);
    @(posedge clk_i); #1;
    id_update_valid_i = 1'b0;
    look("rw.next", 32'h8000_0020, 1'b1, 1'b1, 32'h8000_0400);
    stats("rw", 32'd9, 32'd3);

    // Flush while READY; a same-edge update is dropped
    set_upd(1'b1, 32'h8000_0030, 1'b1, 1'b1, 32'h8000_0500, 1'b0);
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    id_update_valid_i = 1'b0;
    check("flush.ready0", {31'b0, ready_o}, 32'd0);
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk_i); #1;
      check($sformatf("flush.ready%0d", k), {31'b0, ready_o}, {31'b0, k == 64});
    end
    look("flush.miss20", 32'h8000_0020, 1'b0, 1'b0, 32'h8000_0024);
    look("flush.miss30", 32'h8000_0030, 1'b0, 1'b0, 32'h8000_0034);
    stats("flush", 32'd9, 32'd3);

    // Statistics saturation
    dut.r_stat_upd = 32'hFFFF_FFFE;
    dut.r_stat_mis = 32'hFFFF_FFFE;
    upd(32'h8000_0040, 1'b1, 1'b0, 32'h0, 1'b1);
    stats("sat1", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    upd(32'h8000_0040, 1'b1, 1'b0, 32'h0, 1'b1);
    stats("sat2", 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Reset clears stats and readiness
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check("rst2.ready", {31'b0, ready_o}, 32'd0);
    stats("rst2", 32'd0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
